// File: rtl/key_pkg.sv
// Shared encodings for the key event path: event types, key FSM states, widths.
// Latency: none (definitions only).
// Backpressure: not applicable.
package key_pkg;

   // Event type codes as they appear on evt_type.
   typedef enum logic [1:0] {
      EVT_PRESS   = 2'd0,
      EVT_RELEASE = 2'd1,
      EVT_LONG    = 2'd2,
      EVT_REPEAT  = 2'd3
   } evt_t;

   // Per-key press/hold states.
   typedef enum logic [1:0] {
      KEY_IDLE = 2'd0,
      KEY_DOWN = 2'd1,
      KEY_HELD = 2'd2
   } key_st_t;

   // Width of a key index: at least one bit even for a single key.
   function automatic int key_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/key_fsm.sv
// One key: edge detect, ms hold timer, press/hold FSM and a one-deep event slot.
// Latency: a post is offered on req in the same cycle (bypass when the slot is empty).
// Backpressure: slot holds one event; a further post is dropped (ovf set), except
//    RELEASE replaces a pending REPEAT. A post in a granted cycle is always accepted.
// Ports: clk/rst_n; level (active-low key), tick (1 ms strobe), grant (arbiter
//    takes req_type this cycle), ovf_clr; req/req_type (offered event), ovf (sticky).
module key_fsm
   import key_pkg::*;
#(
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200
) (
   input  logic clk,
   input  logic rst_n,
   input  logic level,
   input  logic tick,
   input  logic grant,
   input  logic ovf_clr,
   output logic req,
   output evt_t req_type,
   output logic ovf
);

   localparam int MS_MAX = (LONG_MS > REPEAT_MS) ? LONG_MS : REPEAT_MS;
   localparam int MSW    = (MS_MAX > 1) ? $clog2(MS_MAX) : 1;
   localparam logic [MSW-1:0] LONG_END = MSW'(LONG_MS - 1);
   localparam logic [MSW-1:0] REP_END  = MSW'(REPEAT_MS - 1);

   key_st_t        st, st_n;
   logic [MSW-1:0] ms, ms_n;
   logic           prev;
   logic           armed;
   logic           press, rel;
   logic           post;
   evt_t           post_type;
   logic           slot_vld;
   evt_t           slot_type;
   logic           ovf_hit;

   // A key that is already down when reset ends must be seen released once
   // before it can produce a press; armed tracks that.
   assign press = armed & prev & ~level;
   assign rel   = ~prev & level;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prev  <= 1'b1;
         armed <= 1'b0;
      end else begin
         prev <= level;
         if (level) begin
            armed <= 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         st <= KEY_IDLE;
         ms <= '0;
      end else begin
         st <= st_n;
         ms <= ms_n;
      end
   end

   // Release is tested before the tick so it wins over a timer expiry.
   always_comb begin
      st_n      = st;
      ms_n      = ms;
      post      = 1'b0;
      post_type = EVT_PRESS;
      case (st)
         KEY_IDLE: begin
            if (press) begin
               post      = 1'b1;
               post_type = EVT_PRESS;
               ms_n      = '0;
               st_n      = KEY_DOWN;
            end
         end
         KEY_DOWN: begin
            if (rel) begin
               post      = 1'b1;
               post_type = EVT_RELEASE;
               st_n      = KEY_IDLE;
            end else if (tick) begin
               if (ms == LONG_END) begin
                  post      = 1'b1;
                  post_type = EVT_LONG;
                  ms_n      = '0;
                  st_n      = KEY_HELD;
               end else begin
                  ms_n = ms + MSW'(1);
               end
            end
         end
         KEY_HELD: begin
            if (rel) begin
               post      = 1'b1;
               post_type = EVT_RELEASE;
               st_n      = KEY_IDLE;
            end else if (tick) begin
               if (ms == REP_END) begin
                  post      = 1'b1;
                  post_type = EVT_REPEAT;
                  ms_n      = '0;
               end else begin
                  ms_n = ms + MSW'(1);
               end
            end
         end
         default: begin
            st_n = KEY_IDLE;
         end
      endcase
   end

   // The oldest event goes first: a full slot is offered ahead of a new post.
   assign req      = slot_vld | post;
   assign req_type = slot_vld ? slot_type : post_type;
   assign ovf_hit  = post & slot_vld & ~grant;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         slot_vld  <= 1'b0;
         slot_type <= EVT_PRESS;
         ovf       <= 1'b0;
      end else begin
         if (grant) begin
            // Granted slot content leaves; a post this cycle either went out
            // directly (slot was empty) or refills the freed slot.
            slot_vld <= slot_vld & post;
            if (post) begin
               slot_type <= post_type;
            end
         end else if (post) begin
            if (!slot_vld) begin
               slot_vld  <= 1'b1;
               slot_type <= post_type;
            end else if (post_type == EVT_RELEASE && slot_type == EVT_REPEAT) begin
               slot_type <= EVT_RELEASE;
            end
         end
         if (ovf_hit) begin
            ovf <= 1'b1;
         end else if (ovf_clr) begin
            ovf <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/key_event_ctrl.sv
// Classifies N debounced keys into PRESS/RELEASE/LONG/REPEAT on one event stream.
// Latency: event visible on the outputs the cycle after it is posted.
// Backpressure: valid/ready; outputs hold while evt_valid & ~evt_ready, per-key
//    one-deep slots absorb one event each, overflow is flagged in ovf.
// Ports: clk/rst_n; key_level (active-low levels); evt_valid/evt_ready/evt_key/
//    evt_type (event stream); ovf (sticky per-key drop flags), ovf_clr (clear pulse).
module key_event_ctrl
   import key_pkg::*;
#(
   parameter int N         = 4,
   parameter int TICK_CNT  = 24000,
   parameter int LONG_MS   = 1000,
   parameter int REPEAT_MS = 200,
   localparam int KW       = key_w(N)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [N-1:0]  key_level,
   output logic          evt_valid,
   input  logic          evt_ready,
   output logic [KW-1:0] evt_key,
   output logic [1:0]    evt_type,
   output logic [N-1:0]  ovf,
   input  logic          ovf_clr
);

   localparam int PW = (TICK_CNT > 1) ? $clog2(TICK_CNT) : 1;

   logic [PW-1:0] pre_cnt;
   logic          tick;
   logic [N-1:0]  req;
   evt_t          req_type [N];
   logic [N-1:0]  grant;
   logic [KW-1:0] rr_ptr;
   logic [KW-1:0] sel;
   logic          found;
   logic          load;

   // 1 ms prescaler.
   assign tick = (pre_cnt == PW'(TICK_CNT - 1));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pre_cnt <= '0;
      end else if (tick) begin
         pre_cnt <= '0;
      end else begin
         pre_cnt <= pre_cnt + PW'(1);
      end
   end

   for (genvar i = 0; i < N; i++) begin : g_key
      key_fsm #(
         .LONG_MS   (LONG_MS),
         .REPEAT_MS (REPEAT_MS)
      ) u_key (
         .clk      (clk),
         .rst_n    (rst_n),
         .level    (key_level[i]),
         .tick     (tick),
         .grant    (grant[i]),
         .ovf_clr  (ovf_clr),
         .req      (req[i]),
         .req_type (req_type[i]),
         .ovf      (ovf[i])
      );
   end

   // Round-robin: scan from rr_ptr upward, wrapping modulo N.
   always_comb begin
      int j;
      j     = 0;
      found = 1'b0;
      sel   = '0;
      for (int k = 0; k < N; k++) begin
         j = int'(rr_ptr) + k;
         if (j >= N) begin
            j = j - N;
         end
         if (!found && req[KW'(j)]) begin
            found = 1'b1;
            sel   = KW'(j);
         end
      end
      load  = !evt_valid || evt_ready;
      grant = '0;
      if (load && found) begin
         grant[sel] = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         evt_valid <= 1'b0;
         evt_key   <= '0;
         evt_type  <= 2'd0;
         rr_ptr    <= '0;
      end else if (load) begin
         evt_valid <= found;
         if (found) begin
            evt_key  <= sel;
            evt_type <= req_type[sel];
            rr_ptr   <= (int'(sel) == N - 1) ? '0 : sel + KW'(1);
         end
      end
   end

endmodule
